// File: rtl/gru_uart_pkg.sv
// Shared UART definitions for the GRU host link.
// Used by both the sample loader and the result transmitter.
package gru_uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } uart_state_e;

  // 50 MHz / 115200 baud
  localparam int CLKS_PER_BIT_115200 = 434;

  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 receiver: RXD synchronizer, bit FSM and stop-bit check.
// Emits one-cycle byte_valid / byte_ferr pulses after each frame.
module uart_rx_byte
  import gru_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_data_o,
  output logic       byte_ferr_o,
  output logic       busy_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  uart_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          brk_q, brk_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          s1_q, s2_q;
  logic          rx;

  assign rx = s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      brk_q   <= 1'b0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      s1_q    <= rxd_i;
      s2_q    <= s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      brk_q   <= brk_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    brk_d   = brk_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // after a bad stop, hold off until the line goes high again
        if (brk_q) begin
          if (rx) brk_d = 1'b0;
        end else if (!rx) begin
          state_d = ST_START;
          cnt_d   = '0;
          bit_d   = '0;
        end
      end
      ST_START: begin
        if (cnt_q == HALF) begin
          cnt_d   = '0;
          state_d = rx ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DATA: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          shreg_d = {rx, shreg_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_STOP: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
          if (rx) begin
            valid_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
            brk_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign byte_valid_o = valid_q;
  assign byte_data_o  = shreg_q;
  assign byte_ferr_o  = ferr_q;
  assign busy_o       = (state_q != ST_IDLE);

endmodule

// File: rtl/uart_sample_loader.sv
// Host sample loader: packs UART bytes little-endian into 32-bit
// words and strobes them with a sample-memory address.
module uart_sample_loader
  import gru_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200,
  parameter int NUM_WORDS    = 16,
  parameter int ADDR_W       = 4,
  parameter int TIMEOUT_CLKS = 50000
) (
  input  logic              CLOCK_50,
  input  logic              KEY,
  input  logic              UART_RXD,
  input  logic              rearm,
  output logic              word_valid,
  output logic [ADDR_W-1:0] word_addr,
  output logic [31:0]       word_data,
  output logic              load_done,
  output logic              frame_err,
  output logic              busy
);

  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CLKS - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);
  localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ferr;
  logic              rx_busy;

  logic [1:0]        idx_q, idx_d;
  logic [31:0]       asm_q, asm_d;
  logic              wv_q, wv_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              done_q, done_d;
  logic              ferr_q, ferr_d;
  logic [TW-1:0]     to_q, to_d;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk         (CLOCK_50),
    .rst_n       (KEY),
    .rxd_i       (UART_RXD),
    .byte_valid_o(byte_valid),
    .byte_data_o (byte_data),
    .byte_ferr_o (byte_ferr),
    .busy_o      (rx_busy)
  );

  always_ff @(posedge CLOCK_50 or negedge KEY) begin
    if (!KEY) begin
      idx_q   <= '0;
      asm_q   <= '0;
      wv_q    <= 1'b0;
      wdata_q <= '0;
      addr_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
      to_q    <= '0;
    end else begin
      idx_q   <= idx_d;
      asm_q   <= asm_d;
      wv_q    <= wv_d;
      wdata_q <= wdata_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    idx_d   = idx_q;
    asm_d   = asm_q;
    wv_d    = 1'b0;
    wdata_d = wdata_q;
    addr_d  = addr_q;
    done_d  = done_q;
    ferr_d  = ferr_q;
    to_d    = to_q;

    // address saturates on the last sample
    if (wv_q && addr_q != LAST_ADDR) addr_d = addr_q + ADDR_W'(1);

    if (rx_busy || idx_q == 2'd0) begin
      to_d = '0;
    end else if (to_q == TO_LAST) begin
      to_d  = '0;
      idx_d = '0;
    end else begin
      to_d = to_q + TW'(1);
    end

    if (byte_ferr) begin
      ferr_d = 1'b1;
      idx_d  = '0;
    end else if (byte_valid) begin
      asm_d[{idx_q, 3'b000} +: 8] = byte_data;
      idx_d = idx_q + 2'd1;
      if (idx_q == LAST_IDX && !done_q) begin
        wv_d    = 1'b1;
        wdata_d = asm_d;
        if (addr_q == LAST_ADDR) done_d = 1'b1;
      end
    end

    if (rearm) begin
      idx_d  = '0;
      addr_d = '0;
      done_d = 1'b0;
      ferr_d = 1'b0;
      wv_d   = 1'b0;
      to_d   = '0;
    end
  end

  assign word_valid = wv_q;
  assign word_addr  = addr_q;
  assign word_data  = wdata_q;
  assign load_done  = done_q;
  assign frame_err  = ferr_q;
  assign busy       = rx_busy;

endmodule

// File: doc/uart_sample_loader.md
Name: uart_sample_loader

Overview:
- UART receive path feeding the GRU input-sequence buffer: deserializes 8N1 bytes on UART_RXD and assembles them little-endian into 32-bit words.
- Each word is presented with a write address for the sample memory; load_done is raised once NUM_WORDS words have arrived.
- Sits in GRU_top beside the result transmitter, replacing the hardcoded input sequence when host loading is used.

Parameters:
- CLKS_PER_BIT, 434, CLOCK_50 cycles per UART bit (115200 baud at 50 MHz); minimum 4.
- NUM_WORDS, 16, words per sequence load.
- ADDR_W, 4, word address width; must satisfy 2^ADDR_W >= NUM_WORDS.
- TIMEOUT_CLKS, 50000, idle cycles after which a partial word is discarded.

Ports:
- CLOCK_50  in  1  system clock.
- KEY  in  1  asynchronous active-low reset.
- UART_RXD  in  1  serial input, idle high, asynchronous to CLOCK_50.
- rearm  in  1  single-cycle pulse: clear load_done and word address, start a new load.
- word_valid  out  1  single-cycle strobe; word_addr/word_data valid this cycle.
- word_addr  out  ADDR_W  sample index 0..NUM_WORDS-1.
- word_data  out  32  assembled word; byte 0 received is bits [7:0].
- load_done  out  1  level; high after word NUM_WORDS-1 written, until rearm or reset.
- frame_err  out  1  sticky; set on a stop bit sampled low, cleared by rearm or reset.
- busy  out  1  high while a byte frame is being received.

Behaviour:
- Reset values: word_valid=0, word_addr=0, word_data=0, load_done=0, frame_err=0, busy=0. The RXD synchronizer resets to 1.
- Reset mid-frame aborts everything. The first frame is recognized only after a fresh falling edge.
- UART_RXD passes through a 2-flop synchronizer before use. This adds 2 cycles of latency to every edge.
- Bit FSM states: IDLE, START, DATA, STOP.
  - IDLE: wait for synchronized RXD=0, then go to START and clear the bit counter.
  - START: at CLKS_PER_BIT/2 cycles, resample. If 1, treat as a glitch and return to IDLE with no byte. If 0, go to DATA.
  - DATA: sample every CLKS_PER_BIT cycles, LSB first, 8 bits, then go to STOP.
  - STOP: sample after CLKS_PER_BIT cycles.
    - If 1: the byte is accepted; byte_valid pulses the next cycle.
    - If 0: the byte is dropped, frame_err is set, and the partial word byte index resets to 0.
    - Either way, return to IDLE. If STOP sampled 0, IDLE waits for RXD=1 before re-arming, so a break condition is not read as a start bit.
- busy is high in START, DATA and STOP.
- Word assembly:
  - A 2-bit byte index places each byte into the shift register at [8*idx+7:8*idx].
  - On the 4th accepted byte, word_valid pulses one cycle after byte_valid, with word_data holding the full word and word_addr holding the current address.
  - The address increments after the strobe.
- When word_addr=NUM_WORDS-1 is written, load_done rises in the same cycle as that word_valid.
- Further words while load_done=1 are discarded: no word_valid and no address change.
- Address does not wrap. Only rearm or reset restarts a load.
- Timeout: an idle counter runs whenever byte index≠0 and the FSM is in IDLE.
  - When it reaches TIMEOUT_CLKS, byte index→0 and the partial bytes are discarded.
  - No error flag is raised. The counter clears on every start bit.
- Simultaneous events:
  - rearm in the same cycle as word_valid: rearm wins. That word is still strobed at the old address, then the address becomes 0, load_done=0 and frame_err=0.
  - rearm does not abort a byte in flight.
  - rearm clears the byte index.

Decomposition:
- Shared package gru_uart_pkg holds:
  - UART state encoding (IDLE/START/DATA/STOP);
  - the 50 MHz/115200 CLKS_PER_BIT constant;
  - BYTES_PER_WORD=4.
- The transmitter uses the same package.
- Sub-module uart_rx_byte contains the synchronizer, bit FSM and framing check. Its outputs are byte_valid, byte_data[7:0] and byte_ferr.
- The top of uart_sample_loader handles word assembly, addressing, timeout and flags.

Test Plan:
- CLKS_PER_BIT=8, NUM_WORDS=2. Send 0x78,0x56,0x34,0x12 → one word_valid with addr 0, data 0x12345678, load_done=0.
- Continue with 0xEF,0xBE,0xAD,0xDE → addr 1, data 0xDEADBEEF, load_done rises with that strobe. Extra 4 bytes → no word_valid.
- Start-bit glitch of 3 cycles low → no byte, FSM back in IDLE. Then byte 0xA5 is received correctly.
- Frame 0x55 with stop bit forced 0 → frame_err=1, byte index 0. Next 4 good bytes 0x01..0x04 → data 0x04030201 at the current address.
- Send 2 bytes then idle for TIMEOUT_CLKS+1 (set to 200) → partial word discarded. Next 4 bytes 0x11,0x22,0x33,0x44 → data 0x44332211.
- Assert KEY low mid-DATA bit 4 → all outputs return to reset values. After release, a full word 0xCAFEF00D is received at addr 0. Then rearm after load_done → load_done=0, frame_err=0, addr 0.
